async_fifo_rd_packer: RTL

- Read-side consumer of async_fifo, in the rd_clk domain.
- Pops WIDTH-bit words from the FIFO read port and packs RATIO consecutive words into one RATIO*WIDTH-bit output beat.
- Output is a valid/ready stream with one output register; sustains one FIFO pop per cycle while downstream accepts.
- Sits between async_fifo (rden/data_out/rd_empty) and wide-datapath logic (e.g. 8-bit bytes to 32-bit bus words).

---
 rtl/async_fifo_pkg.sv | 20 ++
 rtl/async_fifo_rd_obuf.sv | 45 ++++
 rtl/async_fifo_rd_packer.sv | 98 +++++++++
 3 files changed

// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: width helpers, lane indexing and keep-mask generation for the FIFO read packer
package async_fifo_pkg;

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    function automatic int to_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic logic [15:0] keep_mask(input int cnt);
        return 16'((32'd1 << cnt) - 32'd1);
    endfunction

endpackage

// File: rtl/async_fifo_rd_obuf.sv
// async_fifo_rd_obuf: single-entry valid/ready output register for the read packer
module async_fifo_rd_obuf #(
    parameter int W = 32,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic [K-1:0] keep_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [K-1:0] keep_o,
    output logic         free_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic [K-1:0] keep_q, keep_d;

    // a load replaces the entry (possibly in the same cycle it is accepted); otherwise hold until accepted
    always_comb begin
        valid_d = load_i || (valid_q && !ready_i);
        data_d  = load_i ? data_i : data_q;
        keep_d  = load_i ? keep_i : keep_q;
    end

    // output entry register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign keep_o  = keep_q;
    assign free_o  = !valid_q || ready_i;
endmodule

// File: rtl/async_fifo_rd_packer.sv
// async_fifo_rd_packer: packs RATIO FIFO words into one wide beat; partial-beat timeout flush under ASYNC_FIFO_RD_PACKER_FLUSH_EN
module async_fifo_rd_packer
    import async_fifo_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   rd_clk,
    input  logic                   arresetn,
    input  logic                   fifo_rd_empty,
    input  logic [WIDTH-1:0]       fifo_data_out,
    output logic                   fifo_rden,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [RATIO*WIDTH-1:0] o_data,
    output logic [RATIO-1:0]       o_keep,
    output logic                   o_busy
);
    localparam int CNT_W = cnt_width(RATIO);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    if (RATIO < 1 || RATIO > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
        $error("async_fifo_rd_packer: RATIO or TIMEOUT out of range");
    end

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RATIO*WIDTH-1:0] acc_q, acc_d, acc_w, load_data;
    logic [RATIO-1:0]       load_keep;
    logic                   out_free, pop, load, flush;

    // the last word of a beat may only be popped when the output register can take the beat
    assign fifo_rden = arresetn && !fifo_rd_empty && (cnt_q < LAST || out_free);
    assign pop       = fifo_rden;
    assign o_busy    = (cnt_q != '0) || o_valid;

`ifdef ASYNC_FIFO_RD_PACKER_FLUSH_EN
    localparam int TO_W = to_width(TIMEOUT);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    logic [TO_W-1:0] idle_q, idle_d;

    // a pop always wins over a pending flush
    assign flush = !pop && (cnt_q != '0) && (idle_q == TO_MAX) && out_free;

    // idle counter saturates at TIMEOUT while the output register is blocked
    always_comb begin
        idle_d = (pop || flush || cnt_q == '0) ? '0 : (idle_q == TO_MAX ? idle_q : idle_q + TO_W'(1));
    end

    // idle counter register
    always_ff @(posedge rd_clk or negedge arresetn) begin
        if (!arresetn) idle_q <= '0;
        else           idle_q <= idle_d;
    end
`else
    assign flush = 1'b0;
`endif

    // accumulator with the current FIFO word dropped into lane cnt
    always_comb begin
        acc_w = acc_q;
        acc_w[lane_lsb(int'(cnt_q), WIDTH) +: WIDTH] = fifo_data_out;
    end

    assign load      = (pop && cnt_q == LAST) || flush;
    assign load_data = flush ? acc_q : acc_w;
    assign load_keep = flush ? RATIO'(keep_mask(int'(cnt_q))) : '1;

    // accumulator clears whenever its contents move to the output register
    always_comb begin
        cnt_d = load ? '0 : (pop ? cnt_q + CNT_W'(1) : cnt_q);
        acc_d = load ? '0 : (pop ? acc_w : acc_q);
    end

    // lane counter and accumulator registers
    always_ff @(posedge rd_clk or negedge arresetn) begin
        if (!arresetn) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    async_fifo_rd_obuf #(.W(RATIO*WIDTH), .K(RATIO)) u_obuf (
        .clk    (rd_clk),
        .rst_n  (arresetn),
        .load_i (load),
        .data_i (load_data),
        .keep_i (load_keep),
        .ready_i(o_ready),
        .valid_o(o_valid),
        .data_o (o_data),
        .keep_o (o_keep),
        .free_o (out_free)
    );
endmodule
